// File: rtl/lin_interp_pkg.sv
// Shared constants and state encoding for the fractional-rate lin1D scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package lin_interp_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 15;
    localparam int ONE            = 1 << DEF_FRAC_BITS;
    localparam int SCALE_MAX      = ONE - 1;

    typedef enum logic [1:0] {
        S_FILL0 = 2'd0,   // waiting for the first sample of a burst
        S_FILL1 = 2'd1,   // waiting for the second sample of a burst
        S_RUN   = 2'd2,   // presenting a pair and weights to lin1D
        S_ADV   = 2'd3    // consuming k new samples before the next output
    } state_t;

endpackage

// File: rtl/lin_phase_acc.sv
// Phase accumulator: holds mu and step, produces the per-output advance k and registered weights.
// Latency: weights are registered from next-cycle mu, so they always match the current mu.
// Backpressure: mu only moves on an accepted output; config is deferred while a burst runs.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cfg_step/cfg_valid   new step request (zero is ignored)
//   cfg_direct           scheduler idle in S_FILL0: a request takes effect immediately
//   advance              output accepted in S_RUN: mu <= frac(mu + step)
//   flush                burst-ending output accepted: mu <= 0, pending step applied
//   k                    integer part of mu + step (samples to consume, 0..2)
//   scale0/scale1        weights for the older/newer sample, Q0.FRAC zero-extended
module lin_phase_acc
    import lin_interp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FRAC_BITS:0]    cfg_step,
    input  logic                  cfg_valid,
    input  logic                  cfg_direct,
    input  logic                  advance,
    input  logic                  flush,
    output logic [1:0]            k,
    output logic [DATA_WIDTH-1:0] scale0,
    output logic [DATA_WIDTH-1:0] scale1
);
    localparam logic [FRAC_BITS:0]   ONE_Q = {1'b1, {FRAC_BITS{1'b0}}};
    localparam logic [FRAC_BITS-1:0] SAT_Q = {FRAC_BITS{1'b1}};
    localparam logic [FRAC_BITS-1:0] LSB_Q = {{(FRAC_BITS-1){1'b0}}, 1'b1};
    localparam int                   PAD   = DATA_WIDTH - FRAC_BITS;

    logic [FRAC_BITS:0]   step;
    logic [FRAC_BITS:0]   pend_step;
    logic                 pend_vld;
    logic [FRAC_BITS-1:0] mu;
    logic [FRAC_BITS-1:0] mu_nxt;
    logic [FRAC_BITS-1:0] w0_nxt;
    logic [FRAC_BITS+1:0] sum;
    logic                 cfg_ok;

    // mu < ONE and step < 2*ONE, so the integer part never exceeds 2.
    assign sum    = {2'b00, mu} + {1'b0, step};
    assign k      = sum[FRAC_BITS+1:FRAC_BITS];
    assign cfg_ok = cfg_valid && (cfg_step != '0);

    always_comb begin
        mu_nxt = mu;
        if (flush) begin
            mu_nxt = '0;
        end else if (advance) begin
            mu_nxt = sum[FRAC_BITS-1:0];
        end
    end

    // ONE - mu taken modulo ONE is the two's complement of mu; mu == 0 would wrap
    // to 0, so that case saturates to the largest representable weight instead.
    assign w0_nxt = (mu_nxt == '0) ? SAT_Q : (~mu_nxt + LSB_Q);

    always_ff @(posedge clk) begin
        if (reset) begin
            mu     <= '0;
            scale0 <= '0;
            scale1 <= '0;
        end else begin
            mu     <= mu_nxt;
            scale0 <= {{PAD{1'b0}}, w0_nxt};
            scale1 <= {{PAD{1'b0}}, mu_nxt};
        end
    end

    // A request that arrives mid-burst is parked and only takes effect when the
    // burst flushes, so one burst never mixes two rates.
    always_ff @(posedge clk) begin
        if (reset) begin
            step      <= ONE_Q;
            pend_step <= '0;
            pend_vld  <= 1'b0;
        end else if (cfg_direct) begin
            if (cfg_ok) begin
                step <= cfg_step;
            end
            pend_vld <= 1'b0;
        end else if (flush) begin
            if (cfg_ok) begin
                step <= cfg_step;
            end else if (pend_vld) begin
                step <= pend_step;
            end
            pend_vld <= 1'b0;
        end else if (cfg_ok) begin
            pend_step <= cfg_step;
            pend_vld  <= 1'b1;
        end
    end

endmodule

// File: rtl/lin_interp_sched.sv
// Scheduler feeding lin1D a sample pair and weight pair per output at a programmable fractional rate.
// Latency: first sched_tvalid one cycle after the second input beat; one output/clock while k == 0.
// Backpressure: outputs hold while sched_tready is low; input is refused while presenting (S_RUN).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cfg_step, cfg_valid         output step (Q1.FRAC), load request
//   in_tdata/tvalid/tlast/tready  IQ sample stream in
//   in0_tdata, in1_tdata        older/newer sample of the pair
//   scale0_tdata, scale1_tdata  weights for in0/in1 (Q0.FRAC)
//   sched_tvalid/tlast/tready   handshake towards lin1D
//   busy                        scheduler is inside a burst (not in S_FILL0)
module lin_interp_sched
    import lin_interp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [FRAC_BITS:0]      cfg_step,
    input  logic                    cfg_valid,
    input  logic [2*DATA_WIDTH-1:0] in_tdata,
    input  logic                    in_tvalid,
    input  logic                    in_tlast,
    output logic                    in_tready,
    output logic [2*DATA_WIDTH-1:0] in0_tdata,
    output logic [2*DATA_WIDTH-1:0] in1_tdata,
    output logic [DATA_WIDTH-1:0]   scale0_tdata,
    output logic [DATA_WIDTH-1:0]   scale1_tdata,
    output logic                    sched_tvalid,
    output logic                    sched_tlast,
    input  logic                    sched_tready,
    output logic                    busy
);
    state_t     state;
    state_t     state_nxt;
    logic [1:0] adv_cnt;
    logic [1:0] k;
    logic       last_seen;
    logic       in_beat;
    logic       run_hs;
    logic       flush;

    lin_phase_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_phase_acc (
        .clk        (clk),
        .reset      (reset),
        .cfg_step   (cfg_step),
        .cfg_valid  (cfg_valid),
        .cfg_direct (state == S_FILL0),
        .advance    (run_hs),
        .flush      (flush),
        .k          (k),
        .scale0     (scale0_tdata),
        .scale1     (scale1_tdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FILL0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_tready    = 1'b0;
        sched_tvalid = 1'b0;
        sched_tlast  = 1'b0;
        case (state)
            S_FILL0: begin
                in_tready = 1'b1;
                if (in_tvalid) state_nxt = S_FILL1;
            end
            S_FILL1: begin
                in_tready = 1'b1;
                if (in_tvalid) state_nxt = S_RUN;
            end
            S_RUN: begin
                sched_tvalid = 1'b1;
                // The burst closes on the first output that would need a new sample.
                sched_tlast  = last_seen && (k != 2'd0);
                if (sched_tready) begin
                    if (sched_tlast) begin
                        state_nxt = S_FILL0;
                    end else if (k != 2'd0) begin
                        state_nxt = S_ADV;
                    end
                end
            end
            S_ADV: begin
                in_tready = 1'b1;
                if (in_tvalid && (adv_cnt == 2'd1)) state_nxt = S_RUN;
            end
            default: state_nxt = S_FILL0;
        endcase
    end

    assign in_beat = in_tvalid && in_tready;
    assign run_hs  = sched_tvalid && sched_tready;
    assign flush   = run_hs && sched_tlast;
    assign busy    = (state != S_FILL0);

    always_ff @(posedge clk) begin
        if (reset) begin
            in0_tdata <= '0;
            in1_tdata <= '0;
            last_seen <= 1'b0;
            adv_cnt   <= '0;
        end else begin
            if (in_beat) begin
                if (state != S_FILL0) begin
                    in0_tdata <= in1_tdata;
                end
                in1_tdata <= in_tdata;
                if (in_tlast) begin
                    last_seen <= 1'b1;
                end
            end
            if (flush) begin
                last_seen <= 1'b0;
            end
            if (run_hs && (k != 2'd0)) begin
                adv_cnt <= k;
            end else if (in_beat && (state == S_ADV)) begin
                adv_cnt <= adv_cnt - 2'd1;
            end
        end
    end

endmodule
